// File: rtl/bnn_pkg.sv
// Shared types and geometry for the BNN frame front/back end.
package bnn_pkg;
  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int N_OUT     = 4;
  localparam int OUT_W     = 7;
  localparam int ROW_CNT_W = $clog2(ROWS);

  typedef logic [ROWS-1:0][COLS-1:0]   frame_t;
  typedef logic [N_OUT-1:0][OUT_W-1:0] result_t;
  typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_e;
endpackage

// File: rtl/bnn_row_assembler.sv
// Collects row-serial image data into a shadow frame and checks frame framing.
module bnn_row_assembler
  import bnn_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            row_valid_i,
  input  logic [COLS-1:0] row_data_i,
  input  logic            row_last_i,
  input  logic            clr_full_i,
  output logic            row_ready_o,
  output frame_t          shadow_o,
  output logic            full_o,
  output logic            err_o
);
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic                 full_q, full_d, err_q;
  frame_t               shadow_q;
  logic                 accept, at_last, bad;

  assign accept  = row_valid_i & ~full_q;
  assign at_last = (row_cnt_q == ROW_CNT_W'(ROWS-1));
  // last flag must coincide exactly with the final row slot
  assign bad     = accept & (row_last_i ^ at_last);

  always_comb begin
    row_cnt_d = row_cnt_q;
    full_d    = full_q & ~clr_full_i;
    if (accept) begin
      if (bad || at_last) row_cnt_d = '0;
      else                row_cnt_d = row_cnt_q + 1'b1;
      if (!bad && at_last) full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_cnt_q <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      shadow_q  <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      full_q    <= full_d;
      err_q     <= bad;
      if (accept && !bad) shadow_q[row_cnt_q] <= row_data_i;
    end
  end

  assign row_ready_o = ~full_q;
  assign shadow_o    = shadow_q;
  assign full_o      = full_q;
  assign err_o       = err_q;
endmodule

// File: rtl/bnn_frame_io.sv
// Streams a frame into the combinational BNN core, waits for it to settle,
// and returns the captured result over a valid/ready stream.
module bnn_frame_io
  import bnn_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            row_valid_i,
  output logic            row_ready_o,
  input  logic [COLS-1:0] row_data_i,
  input  logic            row_last_i,
  output frame_t          frame_o,
  input  result_t         result_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output result_t         res_data_o,
  output logic            frame_err_o,
  output logic            busy_o
);
  state_e     state_q;
  logic [7:0] settle_q;
  frame_t     frame_q, shadow;
  result_t    res_q;
  logic       res_vld_q, busy_q, shadow_full, xfer;

  assign xfer = (state_q == IDLE) & shadow_full;

  bnn_row_assembler u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .row_valid_i (row_valid_i),
    .row_data_i  (row_data_i),
    .row_last_i  (row_last_i),
    .clr_full_i  (xfer),
    .row_ready_o (row_ready_o),
    .shadow_o    (shadow),
    .full_o      (shadow_full),
    .err_o       (frame_err_o)
  );

  // frame_q only moves on the IDLE->SETTLE transfer so the core sees a stable input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      frame_q   <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (shadow_full) begin
          frame_q  <= shadow;
          settle_q <= 8'(SETTLE_CYCLES - 1);
          busy_q   <= 1'b1;
          state_q  <= SETTLE;
        end
        SETTLE: if (settle_q == 8'd0) begin
          res_q     <= result_i;
          res_vld_q <= 1'b1;
          state_q   <= RESULT;
        end else begin
          settle_q <= settle_q - 8'd1;
        end
        RESULT: if (res_ready_i) begin
          res_vld_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_o     = frame_q;
  assign res_valid_o = res_vld_q;
  assign res_data_o  = res_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_bnn_frame_io.sv
// Directed bench for bnn_frame_io with a popcount stand-in for the BNN core.
module tb_bnn_frame_io;
  import bnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic rv, rl, rr, fe, rsv, rsr, bsy;
  logic [COLS-1:0] rd;
  frame_t  fo;
  result_t ri, rdo;

  logic rv1, rl1, rr1, fe1, rsv1, rsr1, bsy1;
  logic [COLS-1:0] rd1;
  frame_t  fo1;
  result_t ri1, rdo1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;

  // Core stand-in: field k = popcount of rows 4k..4k+3
  function automatic result_t core(input frame_t f);
    result_t res;
    for (int k = 0; k < N_OUT; k++) begin
      int s = 0;
      for (int r = 0; r < 4; r++) s += $countones(f[4*k+r]);
      res[k] = 7'(s);
    end
    return res;
  endfunction

  always_comb ri  = core(fo);
  always_comb ri1 = core(fo1);

  bnn_frame_io #(.SETTLE_CYCLES(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .row_valid_i(rv), .row_ready_o(rr), .row_data_i(rd),
    .row_last_i(rl), .frame_o(fo), .result_i(ri), .res_valid_o(rsv), .res_ready_i(rsr),
    .res_data_o(rdo), .frame_err_o(fe), .busy_o(bsy));

  bnn_frame_io #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .row_valid_i(rv1), .row_ready_o(rr1), .row_data_i(rd1),
    .row_last_i(rl1), .frame_o(fo1), .result_i(ri1), .res_valid_o(rsv1), .res_ready_i(rsr1),
    .res_data_o(rdo1), .frame_err_o(fe1), .busy_o(bsy1));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  function automatic frame_t mkframe(input logic [3:0][15:0] g);
    frame_t f;
    for (int r = 0; r < ROWS; r++) f[r] = g[r/4];
    return f;
  endfunction

  // Sends rows 0..nrows-1 of f; returns one cycle after the final accept.
  task automatic send_frame(input frame_t f, input int gap, input int nrows, input int last_pos);
    for (int r = 0; r < nrows; r++) begin
      int w = 0;
      if (gap > 0 && r > 0) begin rv = 1'b0; cycles(gap); end
      rv = 1'b1; rd = f[r]; rl = (r == last_pos);
      while (!rr && w < 200) begin step(); w++; end
      if (w >= 200) begin n_cmp++; n_bad++; $display("FAIL ready_timeout row %0d", r); end
      step();
    end
    rv = 1'b0; rl = 1'b0;
  endtask

  // Clean frame; exactly one result with the given value must come back.
  task automatic run_clean(input string nm, input frame_t f, input result_t exp);
    int n = 0;
    result_t got = '0;
    send_frame(f, 0, ROWS, ROWS-1);
    for (int i = 0; i < 40; i++) begin
      if (rsv) begin n++; got = rdo; end
      step();
    end
    chk({nm, "_count"}, n, 1);
    chk({nm, "_data"}, got, exp);
  endtask

  typedef struct { logic [3:0][15:0] g; int gap; result_t exp; } vec_t;
  vec_t tv[5];
  result_t exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f, prev, fa, fb;
    result_t snap;
    bit stable;

    tv[0] = '{g: {4{16'hA5A5}}, gap: 0, exp: {4{7'd32}}};
    tv[1] = '{g: {16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F}, gap: 0, exp: {7'd64, 7'd48, 7'd32, 7'd16}};
    tv[2] = '{g: {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF}, gap: 3, exp: {7'd0, 7'd0, 7'd64, 7'd64}};
    tv[3] = '{g: {16'h0001, 16'h7FFF, 16'h1000, 16'h8001}, gap: 2, exp: {7'd4, 7'd60, 7'd4, 7'd8}};
    tv[4] = '{g: {4{16'h0000}}, gap: 1, exp: {4{7'd0}}};

    rst_n = 1'b0; rv = 0; rl = 0; rd = '0; rsr = 1'b1;
    rv1 = 0; rl1 = 0; rd1 = '0; rsr1 = 1'b1;
    cycles(3);
    chk("rst_ready", rr, 1); chk("rst_frame", fo, 0); chk("rst_res_valid", rsv, 0);
    chk("rst_res_data", rdo, 0); chk("rst_err", fe, 0); chk("rst_busy", bsy, 0);
    rst_n = 1'b1;
    step();

    // Table-driven frames: latency, frame contents, result
    for (int v = 0; v < 5; v++) begin
      f = mkframe(tv[v].g);
      prev = fo;
      send_frame(f, tv[v].gap, ROWS, ROWS-1);
      chk($sformatf("v%0d_frame_T1", v), fo, prev);
      step();
      chk($sformatf("v%0d_frame_T2", v), fo, f);
      chk($sformatf("v%0d_busy", v), bsy, 1);
      stable = 1;
      for (int i = 0; i < 7; i++) begin step(); if (fo !== f) stable = 0; end
      chk($sformatf("v%0d_valid_early", v), rsv, 0);
      step();
      chk($sformatf("v%0d_valid", v), rsv, 1);
      chk($sformatf("v%0d_result", v), rdo, tv[v].exp);
      step();
      if (fo !== f) stable = 0;
      chk($sformatf("v%0d_frame_stable", v), stable, 1);
      chk($sformatf("v%0d_valid_clear", v), rsv, 0);
    end

    // Backpressure with a second frame loaded behind the held result
    rsr = 1'b0;
    fa = mkframe({16'h00FF, 16'h0F0F, 16'h3333, 16'h5555});
    fb = mkframe({16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF});
    send_frame(fa, 0, ROWS, ROWS-1);
    cycles(9);
    chk("bp_valid", rsv, 1);
    chk("bp_result", rdo, {4{7'd32}});
    snap = rdo;
    send_frame(fb, 0, ROWS, ROWS-1);
    chk("bp_stall", rr, 0);
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rsv !== 1'b1 || rdo !== snap || fo !== fa || rr !== 1'b0) stable = 0;
    end
    chk("bp_hold", stable, 1);
    rsr = 1'b1;
    step();
    chk("bp_handshake", rsv, 0);
    chk("bp_frame_H1", fo, fa);
    step();
    chk("bp_frame_H2", fo, fb);
    cycles(8);
    chk("bp_valid2", rsv, 1);
    chk("bp_result2", rdo, {7'd0, 7'd64, 7'd0, 7'd64});
    step();

    // Early last on row 7
    send_frame(mkframe(tv[1].g), 0, 8, 7);
    chk("early_err", fe, 1);
    step();
    chk("early_err_pulse", fe, 0);
    chk("early_ready", rr, 1);
    run_clean("early_clean", mkframe(tv[0].g), tv[0].exp);

    // Missing last on row 15
    send_frame(mkframe(tv[1].g), 0, ROWS, -1);
    chk("nolast_err", fe, 1);
    step();
    chk("nolast_err_pulse", fe, 0);
    cycles(12);
    chk("nolast_no_xfer", bsy, 0);
    chk("nolast_ready", rr, 1);
    run_clean("nolast_clean", mkframe(tv[3].g), tv[3].exp);

    // Reset while in SETTLE with a half-loaded next frame
    send_frame(mkframe(tv[1].g), 0, ROWS, ROWS-1);
    step();
    send_frame(mkframe(tv[2].g), 0, 5, -1);
    chk("mr_busy", bsy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_frame", fo, 0); chk("mr_valid", rsv, 0); chk("mr_data", rdo, 0);
    chk("mr_busy0", bsy, 0); chk("mr_ready", rr, 1); chk("mr_err", fe, 0);
    step();
    rst_n = 1'b1;
    step();
    run_clean("mr_clean", mkframe(tv[3].g), tv[3].exp);

    // SETTLE_CYCLES=1 instance: 100 back-to-back frames
    fork
      begin : drv
        frame_t sf;
        for (int fr = 0; fr < 100; fr++) begin
          for (int r = 0; r < ROWS; r++) begin
            int w = 0;
            sf[r] = 16'((fr * 16 + r) * 40503 + 4660);
            rv1 = 1'b1; rd1 = sf[r]; rl1 = (r == ROWS-1);
            while (!rr1 && w < 200) begin step(); w++; end
            if (w >= 200) begin n_cmp++; n_bad++; $display("FAIL s1_ready_timeout frame %0d", fr); end
            step();
          end
          exp_q.push_back(core(sf));
        end
        rv1 = 1'b0; rl1 = 1'b0;
      end
      begin : mon
        int got = 0, chg = -100;
        logic pv = 1'b0;
        frame_t pf = fo1;
        for (int t = 0; t < 6000 && got < 100; t++) begin
          step();
          if (fo1 !== pf) begin chg = cyc; pf = fo1; end
          if (rsv1 && !pv) begin
            chk("s1_latency", cyc, chg + 1);
            if (exp_q.size() == 0) begin
              n_cmp++; n_bad++; $display("FAIL s1_extra_result got %h expected none", rdo1);
            end else chk("s1_result", rdo1, exp_q.pop_front());
            got++;
          end
          pv = rsv1;
        end
        chk("s1_count", got, 100);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
